// File: rtl/sonic_onchip_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// Read returns are routed back through a READ_LATENCY-deep {valid, id} tag pipe.
module sonic_onchip_ram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,

    output logic                proto_err
);

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic last_gnt;
    logic rd_issue;
    logic proto_viol;

    logic [READ_LATENCY-1:0] vld_pn;
    logic [READ_LATENCY-1:0] id_pn;
    logic [READ_LATENCY:0]   vld_cat;
    logic [READ_LATENCY:0]   id_cat;

    // last_gnt = 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && (!req1 || last_gnt)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        ram_chipselect = gnt0 | gnt1;
        ram_write      = gnt0 & m0_write;
        if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            ram_write      = m1_write;
        end
    end

    assign ram_clken = 1'b1;

    // A combined read+write is executed as a write only, so it never tags a return.
    assign rd_issue   = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
    assign proto_viol = (m0_read & m0_write) | (m1_read & m1_write);

    assign vld_cat = {vld_pn, rd_issue};
    assign id_cat  = {id_pn, gnt1};

    // Stage boundary: grant cycle -> tag pipe, READ_LATENCY stages to the return.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt  <= 1'b1;
            proto_err <= 1'b0;
            vld_pn    <= '0;
        end else begin
            if (gnt0) begin
                last_gnt <= 1'b0;
            end else if (gnt1) begin
                last_gnt <= 1'b1;
            end
            if (proto_viol) begin
                proto_err <= 1'b1;
            end
            vld_pn <= vld_cat[READ_LATENCY-1:0];
        end
    end

    always_ff @(posedge clk) begin
        id_pn <= id_cat[READ_LATENCY-1:0];
    end

    // Returns are suppressed during reset so in-flight reads are dropped cleanly.
    assign m0_readdatavalid = vld_pn[READ_LATENCY-1] & ~id_pn[READ_LATENCY-1] & ~reset;
    assign m1_readdatavalid = vld_pn[READ_LATENCY-1] &  id_pn[READ_LATENCY-1] & ~reset;

    assign m0_readdata = ram_readdata;
    assign m1_readdata = ram_readdata;

endmodule

// File: tb/tb_sonic_onchip_ram_arbiter.sv
// Bench for sonic_onchip_ram_arbiter: one instance per legal READ_LATENCY, each with its own RAM,
// checked every cycle against a transaction-level model (shadow memory + expected-return queues).
module tb_sonic_onchip_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;

    logic          m0_waitrequest_a, m1_waitrequest_a, m0_readdatavalid_a, m1_readdatavalid_a;
    logic [DW-1:0] m0_readdata_a, m1_readdata_a, ram_writedata_a, ram_readdata_a;
    logic [AW-1:0] ram_address_a;
    logic [BW-1:0] ram_byteenable_a;
    logic          ram_chipselect_a, ram_write_a, ram_clken_a, proto_err_a;

    logic          m0_waitrequest_b, m1_waitrequest_b, m0_readdatavalid_b, m1_readdatavalid_b;
    logic [DW-1:0] m0_readdata_b, m1_readdata_b, ram_writedata_b, ram_readdata_b;
    logic [AW-1:0] ram_address_b;
    logic [BW-1:0] ram_byteenable_b;
    logic          ram_chipselect_b, ram_write_b, ram_clken_b, proto_err_b;

    sonic_onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest_a),
        .m0_readdata(m0_readdata_a), .m0_readdatavalid(m0_readdatavalid_a),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest_a),
        .m1_readdata(m1_readdata_a), .m1_readdatavalid(m1_readdatavalid_a),
        .ram_address(ram_address_a), .ram_byteenable(ram_byteenable_a),
        .ram_chipselect(ram_chipselect_a), .ram_write(ram_write_a),
        .ram_writedata(ram_writedata_a), .ram_clken(ram_clken_a),
        .ram_readdata(ram_readdata_a), .proto_err(proto_err_a)
    );

    sonic_onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest_b),
        .m0_readdata(m0_readdata_b), .m0_readdatavalid(m0_readdatavalid_b),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest_b),
        .m1_readdata(m1_readdata_b), .m1_readdatavalid(m1_readdatavalid_b),
        .ram_address(ram_address_b), .ram_byteenable(ram_byteenable_b),
        .ram_chipselect(ram_chipselect_b), .ram_write(ram_write_b),
        .ram_writedata(ram_writedata_b), .ram_clken(ram_clken_b),
        .ram_readdata(ram_readdata_b), .proto_err(proto_err_b)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hC0000000 ^ (32'(a) * 32'h9E3779B9);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = nd[8*i +: 8];
        return r;
    endfunction

    // RAM models: contents loaded on the first edge (reset is held then), read-before-write.
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    logic [DW-1:0] rd_a_p0, rd_b_p0, rd_b_p1;
    bit ram_init = 1'b0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem_a[i] <= init_val(AW'(i));
                mem_b[i] <= init_val(AW'(i));
            end
            ram_init <= 1'b1;
        end else begin
            rd_a_p0 <= mem_a[ram_address_a];
            rd_b_p0 <= mem_b[ram_address_b];
            rd_b_p1 <= rd_b_p0;
            if (ram_chipselect_a && ram_clken_a && ram_write_a)
                mem_a[ram_address_a] <= merge(mem_a[ram_address_a], ram_writedata_a, ram_byteenable_a);
            if (ram_chipselect_b && ram_clken_b && ram_write_b)
                mem_b[ram_address_b] <= merge(mem_b[ram_address_b], ram_writedata_b, ram_byteenable_b);
        end
    end
    assign ram_readdata_a = rd_a_p0;
    assign ram_readdata_b = rd_b_p1;

    // Reference model state
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } ret_t;

    logic [DW-1:0] shadow [0:(1<<AW)-1];
    ret_t qa[$];
    ret_t qb[$];
    logic m_last;
    logic m_perr;
    bit   m_known = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input int L, input string n, input logic g0, input logic g1,
                             input logic w0, input logic w1, input logic rv0, input logic rv1,
                             input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                             input logic [DW-1:0] ramrd, input logic cs, input logic we,
                             input logic [AW-1:0] ad, input logic [BW-1:0] be,
                             input logic [DW-1:0] wd, input logic ck, input logic pe);
        logic ev0, ev1, ewe;
        logic [DW-1:0] ed;
        ret_t h;
        ev0 = 1'b0;
        ev1 = 1'b0;
        ed  = '0;
        ewe = (g0 & m0_write) | (g1 & m1_write);
        chk({n, "_wait0"}, 32'(w0), 32'((m0_read | m0_write) & ~g0));
        chk({n, "_wait1"}, 32'(w1), 32'((m1_read | m1_write) & ~g1));
        chk({n, "_cs"}, 32'(cs), 32'(g0 | g1));
        chk({n, "_we"}, 32'(we), 32'(ewe));
        if (g0 | g1) begin
            chk({n, "_addr"}, 32'(ad), 32'(g1 ? m1_address : m0_address));
            chk({n, "_be"}, 32'(be), 32'(g1 ? m1_byteenable : m0_byteenable));
            if (ewe) chk({n, "_wdata"}, wd, g1 ? m1_writedata : m0_writedata);
        end
        chk({n, "_clken"}, 32'(ck), 32'd1);
        if (m_known) chk({n, "_proto_err"}, 32'(pe), 32'(m_perr));
        if (L == 1 && qa.size() > 0 && qa[0].due == cyc) begin
            h = qa[0];
            ev0 = ~h.id; ev1 = h.id; ed = h.data;
        end
        if (L == 2 && qb.size() > 0 && qb[0].due == cyc) begin
            h = qb[0];
            ev0 = ~h.id; ev1 = h.id; ed = h.data;
        end
        if (reset) begin
            ev0 = 1'b0;
            ev1 = 1'b0;
        end
        chk({n, "_rdv0"}, 32'(rv0), 32'(ev0));
        chk({n, "_rdv1"}, 32'(rv1), 32'(ev1));
        if (ev0) chk({n, "_rdata0"}, rd0, ed);
        if (ev1) chk({n, "_rdata1"}, rd1, ed);
        chk({n, "_rd0_pass"}, rd0, ramrd);
        chk({n, "_rd1_pass"}, rd1, ramrd);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        logic g0, g1, r0, r1, id;
        logic [AW-1:0] a;
        ret_t e;
        g0 = 1'b0;
        g1 = 1'b0;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (!reset) begin
            if (r0 && r1) begin
                if (m_last) g0 = 1'b1; else g1 = 1'b1;
            end else if (r0) g0 = 1'b1;
            else if (r1) g1 = 1'b1;
        end
        check_dut(1, "a", g0, g1, m0_waitrequest_a, m1_waitrequest_a, m0_readdatavalid_a,
                  m1_readdatavalid_a, m0_readdata_a, m1_readdata_a, ram_readdata_a,
                  ram_chipselect_a, ram_write_a, ram_address_a, ram_byteenable_a,
                  ram_writedata_a, ram_clken_a, proto_err_a);
        check_dut(2, "b", g0, g1, m0_waitrequest_b, m1_waitrequest_b, m0_readdatavalid_b,
                  m1_readdatavalid_b, m0_readdata_b, m1_readdata_b, ram_readdata_b,
                  ram_chipselect_b, ram_write_b, ram_address_b, ram_byteenable_b,
                  ram_writedata_b, ram_clken_b, proto_err_b);
        if (reset) begin
            m_last  = 1'b1;
            m_perr  = 1'b0;
            m_known = 1'b1;
            qa.delete();
            qb.delete();
        end else begin
            if (g0) m_last = 1'b0;
            else if (g1) m_last = 1'b1;
            if ((m0_read && m0_write) || (m1_read && m1_write)) m_perr = 1'b1;
            while (qa.size() > 0 && qa[0].due <= cyc) void'(qa.pop_front());
            while (qb.size() > 0 && qb[0].due <= cyc) void'(qb.pop_front());
            if (g0 | g1) begin
                id = g1;
                a  = g1 ? m1_address : m0_address;
                if (g1 ? m1_write : m0_write) begin
                    shadow[a] = merge(shadow[a], g1 ? m1_writedata : m0_writedata,
                                      g1 ? m1_byteenable : m0_byteenable);
                end else begin
                    e.id = id;
                    e.data = shadow[a];
                    e.due = cyc + 1;
                    qa.push_back(e);
                    e.due = cyc + 2;
                    qb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle_all();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        int c0, c1, rep, prev, g, cnt, first, last, start, op;
        reset = 1'b1;
        idle_all();
        m0_address = '0; m1_address = '0;
        m0_byteenable = '0; m1_byteenable = '0;
        m0_writedata = '0; m1_writedata = '0;
        m_last = 1'b1;
        m_perr = 1'b0;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(AW'(i));

        // Reset: waitrequest mirrors a pending request, no grant.
        step();
        m1_read = 1'b1;
        settle();
        chk("rst_wait1", 32'(m1_waitrequest_a), 32'd1);
        chk("rst_cs", 32'(ram_chipselect_a), 32'd0);
        tick();
        m1_read = 1'b0;
        reset = 1'b0;
        step();

        // Contention from the first cycle after reset.
        m0_read = 1'b1; m0_address = 15'h0010;
        m1_read = 1'b1; m1_address = 15'h0020;
        settle();
        chk("cont_wait0_c0", 32'(m0_waitrequest_a), 32'd0);
        chk("cont_wait1_c0", 32'(m1_waitrequest_a), 32'd1);
        tick();
        m0_read = 1'b0;
        settle();
        chk("cont_rdv0_c1", 32'(m0_readdatavalid_a), 32'd1);
        chk("cont_data0_c1", m0_readdata_a, init_val(15'h0010));
        chk("cont_wait1_c1", 32'(m1_waitrequest_a), 32'd0);
        tick();
        m1_read = 1'b0;
        settle();
        chk("cont_rdv1_c2", 32'(m1_readdatavalid_a), 32'd1);
        chk("cont_data1_c2", m1_readdata_a, init_val(15'h0020));
        tick();
        step();

        // Fairness under continuous contention.
        m0_write = 1'b1; m0_address = 15'h0040; m0_writedata = 32'h000000AA; m0_byteenable = 4'hF;
        m1_write = 1'b1; m1_address = 15'h0041; m1_writedata = 32'h000000BB; m1_byteenable = 4'hF;
        c0 = 0; c1 = 0; rep = 0; prev = -1;
        for (int k = 0; k < 8; k++) begin
            settle();
            g = !m0_waitrequest_a ? 0 : (!m1_waitrequest_a ? 1 : -1);
            if (g == 0) c0++;
            if (g == 1) c1++;
            if (g == prev) rep++;
            prev = g;
            tick();
        end
        chk("fair_m0_writes", 32'(c0), 32'd4);
        chk("fair_m1_writes", 32'(c1), 32'd4);
        chk("fair_repeats", 32'(rep), 32'd0);
        idle_all();
        step();

        // Byte-lane write then read-back on m1.
        m1_write = 1'b1; m1_address = 15'h7FFF; m1_writedata = 32'hA5A5A5A5; m1_byteenable = 4'hF;
        step();
        m1_writedata = 32'h000000FF; m1_byteenable = 4'h1;
        step();
        m1_write = 1'b0; m1_read = 1'b1;
        step();
        m1_read = 1'b0;
        settle();
        chk("byte_rdv1", 32'(m1_readdatavalid_a), 32'd1);
        chk("byte_data", m1_readdata_a, 32'hA5A5A5FF);
        chk("byte_rdv0", 32'(m0_readdatavalid_a), 32'd0);
        tick();
        step();

        // Latency-2 back-to-back reads.
        cnt = 0; first = -1; last = -1; start = cyc;
        for (int k = 0; k < 8; k++) begin
            m0_read = (k < 4);
            m0_address = 15'h0100 + 15'(k);
            settle();
            if (m0_readdatavalid_b) begin
                if (first < 0) first = cyc;
                last = cyc;
                chk("l2_data", m0_readdata_b, init_val(15'h0100 + 15'(cnt)));
                cnt++;
            end
            tick();
        end
        chk("l2_count", 32'(cnt), 32'd4);
        chk("l2_first", 32'(first - start), 32'd2);
        chk("l2_span", 32'(last - first), 32'd3);

        // Reset while a read is in flight.
        m0_read = 1'b1; m0_address = 15'h0010;
        step();
        m0_read = 1'b0; m1_read = 1'b1; reset = 1'b1;
        settle();
        chk("rmid_rdv0_a", 32'(m0_readdatavalid_a), 32'd0);
        chk("rmid_wait1", 32'(m1_waitrequest_a), 32'd1);
        tick();
        reset = 1'b0; m1_read = 1'b0;
        settle();
        chk("rmid_rdv0_b", 32'(m0_readdatavalid_b), 32'd0);
        tick();
        m0_read = 1'b1; m0_address = 15'h0011;
        m1_read = 1'b1; m1_address = 15'h0021;
        settle();
        chk("rmid_win0", 32'(m0_waitrequest_a), 32'd0);
        chk("rmid_lose1", 32'(m1_waitrequest_a), 32'd1);
        tick();
        m0_read = 1'b0;
        step();
        m1_read = 1'b0;
        step();
        step();

        // Read and write together on m0.
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 15'h0050;
        m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
        settle();
        chk("perr_before", 32'(proto_err_a), 32'd0);
        tick();
        idle_all();
        settle();
        chk("perr_set", 32'(proto_err_a), 32'd1);
        tick();
        step();
        step();
        settle();
        chk("perr_sticky", 32'(proto_err_b), 32'd1);
        tick();
        m0_read = 1'b1; m0_address = 15'h0050;
        step();
        m0_read = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        chk("perr_cleared", 32'(proto_err_a), 32'd0);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            op = $urandom_range(0, 99);
            m0_read  = (op >= 35 && op < 65) || op >= 98;
            m0_write = (op >= 65);
            op = $urandom_range(0, 99);
            m1_read  = (op >= 35 && op < 65) || op >= 98;
            m1_write = (op >= 65);
            m0_address = ($urandom_range(0, 9) == 0) ? 15'h7FFF : 15'($urandom_range(0, 15));
            m1_address = ($urandom_range(0, 9) == 0) ? 15'h7FFF : 15'($urandom_range(0, 15));
            m0_byteenable = 4'($urandom_range(0, 15));
            m1_byteenable = 4'($urandom_range(0, 15));
            m0_writedata = $urandom;
            m1_writedata = $urandom;
            step();
        end
        reset = 1'b0;
        idle_all();
        step();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sonic_onchip_ram_arbiter.md
SONIC_ONCHIP_RAM_ARBITER -- requirements
Module: sonic_onchip_ram_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 15, word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, RAM address-to-readdata cycles; legal values are 1 and 2.
REQ-002 Clock and reset SHALL be one clock, `clk`; reset is `reset`, synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- mN_address, in, ADDR_W, requester N word address (N = 0, 1; applies to every mN_ line).
- mN_byteenable, in, DATA_W/8, requester N byte lanes.
- mN_read, in, 1, requester N read request.
- mN_write, in, 1, requester N write request.
- mN_writedata, in, DATA_W, requester N write data.
- mN_waitrequest, out, 1, requester N stall.
- mN_readdata, out, DATA_W, requester N read data.
- mN_readdatavalid, out, 1, requester N read data valid.
- ram_address, out, ADDR_W, RAM address.
- ram_byteenable, out, DATA_W/8, RAM byte enables.
- ram_chipselect, out, 1, RAM select.
- ram_write, out, 1, RAM write strobe.
- ram_writedata, out, DATA_W, RAM write data.
- ram_clken, out, 1, RAM clock enable.
- ram_readdata, in, DATA_W, RAM read data.
- proto_err, out, 1, sticky protocol-error flag.

Function
REQ-004 Requester N SHALL be requesting (reqN) when mN_read | mN_write.
REQ-005 Grant SHALL be combinational, at most one per cycle, round-robin.
- If only one requester is requesting, it is granted.
- If both are requesting, the requester not granted most recently (last_gnt) is granted.
REQ-006 last_gnt SHALL update on the clock edge after any grant; with no request it SHALL hold its value.
REQ-007 mN_waitrequest SHALL equal reqN & ~gntN; it SHALL be 0 when requester N is idle.
REQ-008 RAM command outputs SHALL be driven as follows.
- On a grant: ram_address, ram_byteenable and ram_writedata come from the granted requester; ram_chipselect=1; ram_write = granted mN_write.
- With no grant: ram_chipselect=0, ram_write=0; other RAM outputs are don't-care but SHALL NOT be X in simulation (hold requester 0 values).
REQ-009 ram_clken SHALL be constant 1.
REQ-010 When a requester asserts read and write together, write SHALL take precedence: no read is tagged, and proto_err SHALL set and stay set until reset.
REQ-011 Each granted read SHALL enter a READ_LATENCY-deep tag shift register holding {valid, requester id}.
REQ-012 mN_readdatavalid SHALL be 1 exactly READ_LATENCY cycles after the granted read cycle, only for the tagged requester.
REQ-013 mN_readdata SHALL equal ram_readdata for both requesters at all times; it is meaningful only when readdatavalid=1.
REQ-014 Back-to-back reads, from either or alternating requesters, SHALL sustain one read per cycle with returns in grant order and no bubbles.
REQ-015 A write SHALL complete in its grant cycle and produce no readdatavalid.
REQ-016 A write granted in the cycle after a read to the same address SHALL NOT affect that read's returned data; the data is whatever the RAM returns.
REQ-017 The grant decision SHALL use only the current cycle's requests and last_gnt; in-flight reads SHALL NOT block new grants.
REQ-018 Total RTL SHALL need no FIFO; state is limited to last_gnt, the tag shift register and proto_err.

Reset
REQ-019 In a cycle with reset=1:
- last_gnt=1, so requester 0 wins the first contention;
- the tag shift register is cleared;
- proto_err=0.
REQ-020 Reads in flight when reset asserts SHALL be dropped; no readdatavalid SHALL appear for them.
REQ-021 Grants SHALL be inhibited while reset=1:
- mN_waitrequest = reqN;
- ram_chipselect=0, ram_write=0.
REQ-022 Out of reset, all readdatavalid SHALL be 0 and both waitrequests SHALL be 0 with requests idle.

Verification
REQ-023 Contention: both requesters read (m0 addr 0x0010, m1 addr 0x0020) from the first cycle after reset -> m0 granted cycle 0, m1 granted cycle 1. With READ_LATENCY=1:
- m0_readdatavalid in cycle 1 with data from 0x0010;
- m1_readdatavalid in cycle 2 with data from 0x0020;
- m1_waitrequest=1 in cycle 0 only.
REQ-024 Fairness: both requesters hold continuous write requests for 8 cycles -> grants alternate m0,m1,m0,...; exactly 4 writes per requester; never two consecutive grants to the same requester.
REQ-025 Byte write then read: m1 writes 0xA5A5A5A5 with byteenable 0xF to 0x7FFF, then writes 0x000000FF with byteenable 0x1, then reads 0x7FFF -> m1_readdata=0xA5A5A5FF with m1_readdatavalid; m0_readdatavalid stays 0.
REQ-026 Latency 2: with READ_LATENCY=2, m0 reads on 4 consecutive cycles -> readdatavalid on cycles 2..5 in address order; no gaps.
REQ-027 Reset mid-read: m0 read granted, reset asserted the next cycle -> no m0_readdatavalid occurs; after release, m0 wins the first contention against m1.
REQ-028 Protocol error: m0 asserts read=1 and write=1 together -> write performed, no readdatavalid, proto_err=1 until reset.
